// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and pattern constants for the scan controller
package seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] PAT110 = 3'b110;
  localparam logic [2:0] PAT101 = 3'b101;

endpackage

// File: rtl/seq_win3_match.sv
// rtl/seq_win3_match.sv - 3-bit sliding window matcher with registered hit strobes
module seq_win3_match
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_win_vld,
  input  logic i_x,
  output logic o_hit110,
  output logic o_hit101
);

  logic [1:0] r_hist;
  logic       r_hit110;
  logic       r_hit101;
  logic [2:0] w_win;

  assign w_win = {r_hist, i_x};

  // Shift the presented bit into history and register whether the completed window matches.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hist   <= 2'b00;
      r_hit110 <= 1'b0;
      r_hit101 <= 1'b0;
    end else if (i_clr) begin
      r_hist   <= 2'b00;
      r_hit110 <= 1'b0;
      r_hit101 <= 1'b0;
    end else if (i_en) begin
      r_hist   <= {r_hist[0], i_x};
      r_hit110 <= i_win_vld && (w_win == PAT110);
      r_hit101 <= i_win_vld && (w_win == PAT101);
    end else begin
      r_hit110 <= 1'b0;
      r_hit101 <= 1'b0;
    end
  end

  assign o_hit110 = r_hit110;
  assign o_hit101 = r_hit101;

endmodule

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - word serialiser that counts overlapping 110/101 windows per scan
module seq_scan_ctrl
  import seq_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  din,
  output logic          ser_x,
  output logic          ser_vld,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt110,
  output logic [CW-1:0] cnt101
);

  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  logic [1:0]    r_state;
  logic [W-1:0]  r_shreg;
  logic [IW-1:0] r_idx;
  logic          r_ser_x;
  logic [CW-1:0] r_cnt110;
  logic [CW-1:0] r_cnt101;

  logic w_accept;
  logic w_shift;
  logic w_abort;
  logic w_last;
  logic w_win_en;
  logic w_win_x;
  logic w_win_vld;
  logic w_hit110;
  logic w_hit101;

  assign w_accept = (r_state == ST_IDLE) && start && !abort;
  assign w_shift  = (r_state == ST_SHIFT);
  assign w_abort  = w_shift && abort;
  assign w_last   = w_shift && (r_idx == LAST_IDX);

  // The matcher is fed the bit that is about to appear on ser_x, so its registered
  // hit lines up with the cycle that presents the window's last bit and the counter
  // can be bumped at the end of that same cycle, leaving counts final in DONE.
  assign w_win_en  = w_accept || (w_shift && !abort && !w_last);
  assign w_win_x   = w_accept ? din[W-1] : r_shreg[W-1];
  assign w_win_vld = w_shift && (r_idx != '0);

  seq_win3_match u_match (
    .clk       (clk),
    .rstn      (rstn),
    .i_clr     (w_abort),
    .i_en      (w_win_en),
    .i_win_vld (w_win_vld),
    .i_x       (w_win_x),
    .o_hit110  (w_hit110),
    .o_hit101  (w_hit101)
  );

  // Control FSM: IDLE -> SHIFT for W cycles -> DONE for one cycle -> IDLE; abort returns to IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_accept) r_state <= ST_SHIFT;
        ST_SHIFT: begin
          if (abort)       r_state <= ST_IDLE;
          else if (w_last) r_state <= ST_DONE;
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Shift register, bit index and serial output; the MSB is presented directly on acceptance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shreg <= '0;
      r_idx   <= '0;
      r_ser_x <= 1'b0;
    end else if (w_accept) begin
      r_shreg <= {din[W-2:0], 1'b0};
      r_idx   <= '0;
      r_ser_x <= din[W-1];
    end else if (w_shift) begin
      if (abort || w_last) begin
        r_ser_x <= 1'b0;
      end else begin
        r_ser_x <= r_shreg[W-1];
        r_shreg <= {r_shreg[W-2:0], 1'b0};
        r_idx   <= r_idx + IW'(1);
      end
    end
  end

  // Pattern counters: cleared on accept or abort, otherwise bumped by matcher hits during SHIFT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt110 <= '0;
      r_cnt101 <= '0;
    end else if (w_accept || w_abort) begin
      r_cnt110 <= '0;
      r_cnt101 <= '0;
    end else if (w_shift) begin
      if (w_hit110) r_cnt110 <= r_cnt110 + CW'(1);
      if (w_hit101) r_cnt101 <= r_cnt101 + CW'(1);
    end
  end

  assign ser_x   = r_ser_x;
  assign ser_vld = w_shift;
  assign busy    = w_shift;
  assign done    = (r_state == ST_DONE);
  assign cnt110  = r_cnt110;
  assign cnt101  = r_cnt101;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - scoreboard bench for seq_scan_ctrl
module tb_seq_scan_ctrl;

  localparam int W  = 8;
  localparam int CW = 3;

  typedef struct {
    logic [W-1:0]  word;
    logic [CW-1:0] c110;
    logic [CW-1:0] c101;
  } exp_t;

  logic          clk;
  logic          rstn;
  logic          start;
  logic          abort;
  logic [W-1:0]  din;
  logic          ser_x;
  logic          ser_vld;
  logic          busy;
  logic          done;
  logic [CW-1:0] cnt110;
  logic [CW-1:0] cnt101;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  seq_scan_ctrl #(.W(W), .CW(CW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .abort   (abort),
    .din     (din),
    .ser_x   (ser_x),
    .ser_vld (ser_vld),
    .busy    (busy),
    .done    (done),
    .cnt110  (cnt110),
    .cnt101  (cnt101)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: assemble the serial word while ser_vld is high, compare against the scoreboard on done.
  initial begin : monitor
    logic [W-1:0] word;
    int nbits;
    exp_t e;
    word  = '0;
    nbits = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        word  = '0;
        nbits = 0;
      end else if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          e = sb.pop_front();
          check("ser_word", 32'(word), 32'(e.word));
          check("ser_len", 32'(nbits), 32'(W));
          check("cnt110", 32'(cnt110), 32'(e.c110));
          check("cnt101", 32'(cnt101), 32'(e.c101));
        end
        word  = '0;
        nbits = 0;
      end else if (ser_vld) begin
        word  = {word[W-2:0], ser_x};
        nbits = nbits + 1;
      end else begin
        word  = '0;
        nbits = 0;
      end
    end
  end

  task automatic run_scan(input logic [W-1:0] d, input int e110, input int e101);
    int n;
    sb.push_back('{d, CW'(e110), CW'(e101)});
    din   = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_latency", 32'(n), 32'(W));
    @(posedge clk); #1;
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
    check("hold_cnt110", 32'(cnt110), 32'(e110));
    check("hold_cnt101", 32'(cnt101), 32'(e101));
  endtask

  initial begin : stim
    int cyc;
    int last_done;
    int ndone;
    rstn  = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    din   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {25'd0, ser_x, ser_vld, busy, done, cnt110, cnt101}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Reset mid-scan after three SHIFT cycles.
    din   = 8'b1101_1011;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("mid_reset_outputs", {25'd0, ser_x, ser_vld, busy, done, cnt110, cnt101}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      check("post_reset_idle", {30'd0, busy, done}, 32'd0);
    end

    // Basic and overlap scans.
    run_scan(8'b1101_1011, 2, 2);
    run_scan(8'b1010_1010, 0, 3);
    run_scan(8'b1100_1100, 2, 0);
    run_scan(8'hFF, 0, 0);

    // Abort in SHIFT cycle 4, then an immediate new start.
    din   = 8'b1101_1011;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_scan_cnt110", 32'(cnt110), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_state", {27'd0, busy, done, ser_vld, 2'b00}, 32'd0);
    check("abort_counts", {26'd0, cnt110, cnt101}, 32'd0);
    run_scan(8'b1010_1010, 0, 3);

    // Start held high: back-to-back scans, din changes during SHIFT.
    sb.push_back('{8'b1101_1011, 3'd2, 3'd2});
    sb.push_back('{8'b1100_1100, 3'd2, 3'd0});
    sb.push_back('{8'hFF, 3'd0, 3'd0});
    din       = 8'b1101_1011;
    start     = 1'b1;
    cyc       = 0;
    last_done = 0;
    ndone     = 0;
    while (ndone < 3 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 3)  din = 8'b1100_1100;
      if (cyc == 13) din = 8'hFF;
      if (cyc == 21) start = 1'b0;
      if (done) begin
        if (ndone > 0) check("done_spacing", 32'(cyc - last_done), 32'd10);
        last_done = cyc;
        ndone++;
      end
    end
    start = 1'b0;
    check("b2b_done_count", 32'(ndone), 32'd3);
    @(posedge clk); #1;

    // Simultaneous start and abort in IDLE.
    din   = 8'b1010_1010;
    start = 1'b1;
    abort = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("start_abort_busy", 32'(busy), 32'd0);
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
